// File: rtl/biriscv_divider_iter_if.sv
// Opcode/operand bundle and writeback signals for the iterative divider.
// master = issue side driving opcodes, slave = the divider.
interface biriscv_divider_iter_if;
   logic        opcode_valid_i;
   logic [31:0] opcode_opcode_i;
   logic [31:0] opcode_pc_i;
   logic        opcode_invalid_i;
   logic [4:0]  opcode_rd_idx_i;
   logic [4:0]  opcode_ra_idx_i;
   logic [4:0]  opcode_rb_idx_i;
   logic [31:0] opcode_ra_operand_i;
   logic [31:0] opcode_rb_operand_i;
   logic        busy_o;
   logic        writeback_valid_o;
   logic [31:0] writeback_value_o;

   modport master (
      output opcode_valid_i, opcode_opcode_i, opcode_pc_i, opcode_invalid_i,
             opcode_rd_idx_i, opcode_ra_idx_i, opcode_rb_idx_i,
             opcode_ra_operand_i, opcode_rb_operand_i,
      input  busy_o, writeback_valid_o, writeback_value_o
   );

   modport slave (
      input  opcode_valid_i, opcode_opcode_i, opcode_pc_i, opcode_invalid_i,
             opcode_rd_idx_i, opcode_ra_idx_i, opcode_rb_idx_i,
             opcode_ra_operand_i, opcode_rb_operand_i,
      output busy_o, writeback_valid_o, writeback_value_o
   );
endinterface

// File: rtl/biriscv_divider_iter.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional macro DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow finish in one cycle.
module biriscv_divider_iter (
   input  logic                          clk_i,
   input  logic                          rst_i,
   biriscv_divider_iter_if.slave         bus
);
   localparam logic [31:0] INST_DIV       = 32'h02004033;
   localparam logic [31:0] INST_DIV_MASK  = 32'hfe00707f;
   localparam logic [31:0] INST_DIVU      = 32'h02005033;
   localparam logic [31:0] INST_DIVU_MASK = 32'hfe00707f;
   localparam logic [31:0] INST_REM       = 32'h02006033;
   localparam logic [31:0] INST_REM_MASK  = 32'hfe00707f;
   localparam logic [31:0] INST_REMU      = 32'h02007033;
   localparam logic [31:0] INST_REMU_MASK = 32'hfe00707f;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [4:0]  count_q, count_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] quot_q, quot_d;
   logic [31:0] divisor_q, divisor_d;
   logic        q_neg_q, q_neg_d;
   logic        r_neg_q, r_neg_d;
   logic        rem_sel_q, rem_sel_d;
   logic        dbz_q, dbz_d;
   logic        busy_q, busy_d;
   logic        valid_q, valid_d;
   logic [31:0] value_q, value_d;

   logic        is_div, is_divu, is_rem, is_remu, signed_op, accept;
   logic [31:0] a, b, abs_a, abs_b, q_res, r_res;
   logic [32:0] trial;

   logic unused_bundle;
   assign unused_bundle = ^{bus.opcode_pc_i, bus.opcode_rd_idx_i,
                            bus.opcode_ra_idx_i, bus.opcode_rb_idx_i};

   always_comb begin
      is_div    = (bus.opcode_opcode_i & INST_DIV_MASK)  == INST_DIV;
      is_divu   = (bus.opcode_opcode_i & INST_DIVU_MASK) == INST_DIVU;
      is_rem    = (bus.opcode_opcode_i & INST_REM_MASK)  == INST_REM;
      is_remu   = (bus.opcode_opcode_i & INST_REMU_MASK) == INST_REMU;
      signed_op = is_div | is_rem;
      // state check keeps a fast-path op from being overrun in its DONE cycle
      accept    = bus.opcode_valid_i & ~bus.opcode_invalid_i & ~busy_q &
                  (is_div | is_divu | is_rem | is_remu) & (state_q == S_IDLE);
      a         = bus.opcode_ra_operand_i;
      b         = bus.opcode_rb_operand_i;
      abs_a     = (signed_op & a[31]) ? -a : a;
      abs_b     = (signed_op & b[31]) ? -b : b;
      trial     = {rem_q, quot_q[31]} - {1'b0, divisor_q};
      q_res     = (q_neg_q & ~dbz_q) ? -quot_q : quot_q;
      r_res     = r_neg_q ? -rem_q : rem_q;
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      rem_d     = rem_q;
      quot_d    = quot_q;
      divisor_d = divisor_q;
      q_neg_d   = q_neg_q;
      r_neg_d   = r_neg_q;
      rem_sel_d = rem_sel_q;
      dbz_d     = dbz_q;
      busy_d    = busy_q;
      valid_d   = 1'b0;
      value_d   = value_q;
      case (state_q)
         S_IDLE: if (accept) begin
            q_neg_d   = signed_op & (a[31] ^ b[31]);
            r_neg_d   = signed_op & a[31];
            rem_sel_d = is_rem | is_remu;
            dbz_d     = (b == 32'd0);
            divisor_d = abs_b;
            count_d   = 5'd31;
            rem_d     = 32'd0;
            quot_d    = abs_a;
            state_d   = S_RUN;
            busy_d    = 1'b1;
`ifdef DIV_FAST_SPECIAL_EN
            // preload what the iteration would have produced and skip it
            if (b == 32'd0) begin
               quot_d  = 32'hffffffff;
               rem_d   = abs_a;
               state_d = S_DONE;
               busy_d  = 1'b0;
            end else if (signed_op && a == 32'h80000000 && b == 32'hffffffff) begin
               quot_d  = 32'h80000000;
               rem_d   = 32'd0;
               state_d = S_DONE;
               busy_d  = 1'b0;
            end
`endif
         end
         S_RUN: begin
            if (!trial[32]) begin
               rem_d  = trial[31:0];
               quot_d = {quot_q[30:0], 1'b1};
            end else begin
               rem_d  = {rem_q[30:0], quot_q[31]};
               quot_d = {quot_q[30:0], 1'b0};
            end
            count_d = count_q - 5'd1;
            if (count_q == 5'd0) state_d = S_DONE;
         end
         S_DONE: begin
            value_d = rem_sel_q ? r_res : q_res;
            valid_d = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         count_q   <= 5'd0;
         rem_q     <= 32'd0;
         quot_q    <= 32'd0;
         divisor_q <= 32'd0;
         q_neg_q   <= 1'b0;
         r_neg_q   <= 1'b0;
         rem_sel_q <= 1'b0;
         dbz_q     <= 1'b0;
         busy_q    <= 1'b0;
         valid_q   <= 1'b0;
         value_q   <= 32'd0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         rem_q     <= rem_d;
         quot_q    <= quot_d;
         divisor_q <= divisor_d;
         q_neg_q   <= q_neg_d;
         r_neg_q   <= r_neg_d;
         rem_sel_q <= rem_sel_d;
         dbz_q     <= dbz_d;
         busy_q    <= busy_d;
         valid_q   <= valid_d;
         value_q   <= value_d;
      end
   end

   assign bus.busy_o            = busy_q;
   assign bus.writeback_valid_o = valid_q;
   assign bus.writeback_value_o = value_q;
endmodule
